// File: rtl/mul_add_cu_pkg.sv
// Shared definitions for the q*b + r reconstruct unit: FSM encodings,
// default operand width and the iteration counter width.
package mul_add_cu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Counter must be able to hold the value WIDTH itself (end-of-loop marker).
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_add_dp.sv
// Datapath for the reconstruct unit: operand registers, 2*WIDTH+1 bit
// accumulator, iteration counter and a single shared adder. The multiplicand
// is kept pre-shifted by the counter value, so every step is one add.
module mul_add_dp
    import mul_add_cu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0]   q_sh;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   r_reg;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH:0]   addend;
    logic [2*WIDTH:0]   sum;

    // All WIDTH multiplier bits consumed; the next CALC cycle adds r.
    assign last = (cnt == CW'(WIDTH));

    // Shared adder: shifted multiplicand during steps, zero-extended r on finish.
    always_comb begin
        addend = '0;
        if (step && q_sh[0]) begin
            addend = {1'b0, mcand};
        end else if (finish) begin
            addend = {{(WIDTH+1){1'b0}}, r_reg};
        end
        sum = acc + addend;
    end

    // Operand capture, shift-add iteration and final result/overflow capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_sh     <= '0;
            mcand    <= '0;
            r_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (load) begin
            q_sh  <= q;
            mcand <= {{WIDTH{1'b0}}, b};
            r_reg <= r;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc   <= sum;
            q_sh  <= q_sh >> 1;
            mcand <= mcand << 1;
            cnt   <= cnt + CW'(1);
        end else if (finish) begin
            acc      <= sum;
            result   <= sum[WIDTH-1:0];
            overflow <= |sum[2*WIDTH:WIDTH];
        end
    end

endmodule

// File: rtl/mul_add_cu.sv
// Sequential reconstruct unit: result = q*b + r via shift-add, using the
// level-start / held-done handshake shared with the modulo unit.
// Fixed latency: start sampled at edge k gives done after edge k+WIDTH+2.
module mul_add_cu
    import mul_add_cu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    state_t state;
    logic   load;
    logic   step;
    logic   finish;
    logic   last;

    assign load   = (state == LOAD);
    assign step   = (state == CALC) && !last;
    assign finish = (state == CALC) && last;

    // Control FSM with registered busy/done flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= CALC;
                end
                CALC: begin
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    mul_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .finish   (finish),
        .q        (q),
        .b        (b),
        .r        (r),
        .last     (last),
        .result   (result),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_mul_add_cu.sv
// Scoreboard bench for mul_add_cu: expected q*b + r results are queued when
// an operation is issued and compared when done rises.
module tb_mul_add_cu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] q, b, r;
    logic [W-1:0] result;
    logic         overflow, busy, done;

    typedef struct packed {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mul_add_cu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .q        (q),
        .b        (b),
        .r        (r),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands, raise start and queue the reference result.
    task automatic issue(input logic [W-1:0] qi, input logic [W-1:0] bi, input logic [W-1:0] ri);
        logic [2*W:0] full;
        exp_t e;
        full = {{(W+1){1'b0}}, qi} * {{(W+1){1'b0}}, bi} + {{(W+1){1'b0}}, ri};
        e.res = full[W-1:0];
        e.ovf = |full[2*W:W];
        sb.push_back(e);
        q = qi;
        b = bi;
        r = ri;
        start = 1'b1;
    endtask

    // Wait for done; n = clock edges taken, including the one sampling start.
    task automatic await_done(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 200);
        if (!done) check({tag, "_timeout"}, {63'b0, done}, 64'd1);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        check({tag, "_sb_depth"}, sb.size(), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_ovf"}, overflow, e.ovf);
        end
    endtask

    // Full operation: issue, wait, check latency and result, then drop start.
    task automatic run_simple(input string tag, input logic [W-1:0] qi,
                              input logic [W-1:0] bi, input logic [W-1:0] ri);
        int n;
        issue(qi, bi, ri);
        await_done(tag, n);
        check({tag, "_latency"}, n - 1, W + 2);
        check({tag, "_busy_at_done"}, busy, 64'd0);
        compare_out(tag);
        start = 1'b0;
        tick();
        check({tag, "_done_drop"}, done, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t dropped;
        logic [W-1:0] qa, ra;

        rst = 1'b1; start = 1'b0; q = '0; b = '0; r = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_result", result, 64'd0);
        check("rst_ovf", overflow, 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);

        // q=7 b=5 r=3 with start held through DONE
        issue(32'd7, 32'd5, 32'd3);
        tick();
        check("t1_busy_load", busy, 64'd1);
        check("t1_done_load", done, 64'd0);
        await_done("t1", n);
        check("t1_latency", n, W + 2);
        compare_out("t1");
        check("t1_value", result, 64'd38);
        repeat (3) begin
            tick();
            check("t1_done_held", done, 64'd1);
            check("t1_busy_held", busy, 64'd0);
        end
        start = 1'b0;
        tick();
        check("t1_done_idle", done, 64'd0);
        check("t1_result_hold", result, 64'd38);

        run_simple("zero_q", 32'd0, 32'hDEADBEEF, 32'h1234);
        run_simple("q_max_b1", 32'hFFFFFFFF, 32'd1, 32'd0);
        run_simple("ovf_mul", 32'hFFFFFFFF, 32'd2, 32'd0);
        check("ovf_mul_flag", overflow, 64'd1);
        run_simple("ovf_add", 32'd1, 32'hFFFFFFFF, 32'd1);
        check("ovf_add_result", result, 64'd0);

        // Operands and start change mid-CALC; must be ignored
        issue(32'd3, 32'd4, 32'd1);
        repeat (6) tick();
        q = 32'hFF; b = 32'hFF; r = 32'hFF;
        start = 1'b0;
        await_done("midcalc", n);
        check("midcalc_latency", n + 6 - 1, W + 2);
        compare_out("midcalc");
        check("midcalc_value", result, 64'd13);
        tick();
        check("midcalc_done_1cyc", done, 64'd0);
        check("midcalc_busy", busy, 64'd0);

        // Reset in CALC cycle 10 aborts the operation
        issue(32'd9, 32'd9, 32'd9);
        repeat (11) tick();
        check("abort_busy_pre", busy, 64'd1);
        rst = 1'b1;
        start = 1'b0;
        tick();
        rst = 1'b0;
        dropped = sb.pop_back();
        check("abort_result", result, 64'd0);
        check("abort_ovf", overflow, 64'd0);
        check("abort_busy", busy, 64'd0);
        check("abort_done", done, 64'd0);
        tick();
        check("abort_no_done", done, 64'd0);
        run_simple("after_abort", 32'd9, 32'd9, 32'd9);
        check("after_abort_value", result, 64'd90);

        // Round trip from modulo unit outputs, then back-to-back run
        qa = 32'd1000 / 32'd7;
        ra = 32'd1000 % 32'd7;
        run_simple("roundtrip", qa, 32'd7, ra);
        check("roundtrip_value", result, 64'd1000);
        run_simple("b2b", 32'd12345, 32'd678, 32'd9);
        check("b2b_value", result, 64'd8369919);

        for (int i = 0; i < 4; i++) begin
            run_simple("rand", $urandom, $urandom, $urandom);
        end

        check("sb_empty_end", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
